// File: rtl/basic_uart_pkg.sv
// Shared constants for the UART command link: protocol bytes and responder state encoding.
// Combinational definitions only; no latency and no flow control of their own.
package basic_uart_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_GET_ADDR  = 3'd1;
  localparam logic [2:0] ST_GET_DATA  = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_GET_ADDR  = ST_GET_ADDR,
    S_GET_DATA  = ST_GET_DATA,
    S_SEND      = ST_SEND,
    S_WAIT_DONE = ST_WAIT_DONE
  } state_t;

endpackage

// File: rtl/basic_uart_cmd_responder.sv
// Decodes host read/write byte commands against a 16x8 register file; reply 1 cycle after last byte at best.
// Stalls in SEND while tx_ready is low; bytes arriving while a reply is pending are dropped with err_ev.
module basic_uart_cmd_responder
  import basic_uart_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_dat,
  input  logic         rx_dat_ev,
  input  logic         tx_ready,
  input  logic         tx_done_ev,
  output logic [7:0]   tx_dat,
  output logic         tx_wr_ev,
  output logic [127:0] regs,
  output logic         busy,
  output logic         err_ev
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  state_t        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [3:0]    addr_q, addr_d;
  logic [7:0]    resp_q, resp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_dat_d;
  logic          tx_wr_d, err_d, reg_we;
  logic [127:0]  regs_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      is_wr_q  <= 1'b0;
      addr_q   <= 4'd0;
      resp_q   <= 8'h00;
      cnt_q    <= '0;
      tx_dat   <= 8'h00;
      tx_wr_ev <= 1'b0;
      err_ev   <= 1'b0;
      regs_q   <= '0;
    end else begin
      state_q  <= state_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      resp_q   <= resp_d;
      cnt_q    <= cnt_d;
      tx_dat   <= tx_dat_d;
      tx_wr_ev <= tx_wr_d;
      err_ev   <= err_d;
      if (reg_we) regs_q[{addr_q, 3'b000} +: 8] <= rx_dat;
    end
  end

  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    resp_d   = resp_q;
    cnt_d    = '0;
    tx_dat_d = tx_dat;
    tx_wr_d  = 1'b0;
    err_d    = 1'b0;
    reg_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_dat_ev) begin
          if (rx_dat == CMD_WR || rx_dat == CMD_RD) begin
            is_wr_d = (rx_dat == CMD_WR);
            state_d = S_GET_ADDR;
          end else begin
            resp_d  = RSP_NAK;
            err_d   = 1'b1;
            state_d = S_SEND;
          end
        end
      end
      S_GET_ADDR, S_GET_DATA: begin
        // An arriving byte always beats a timeout in the same cycle.
        if (rx_dat_ev) begin
          if (state_q == S_GET_DATA) begin
            reg_we  = 1'b1;
            resp_d  = RSP_ACK;
            state_d = S_SEND;
          end else if (rx_dat[7:4] != 4'd0) begin
            resp_d  = RSP_NAK;
            err_d   = 1'b1;
            state_d = S_SEND;
          end else if (!is_wr_q) begin
            resp_d  = regs_q[{rx_dat[3:0], 3'b000} +: 8];
            state_d = S_SEND;
          end else begin
            addr_d  = rx_dat[3:0];
            state_d = S_GET_DATA;
          end
        end else if (cnt_q >= CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SEND: begin
        if (rx_dat_ev) begin
          err_d = 1'b1;
        end else if (tx_ready) begin
          tx_dat_d = resp_q;
          tx_wr_d  = 1'b1;
          state_d  = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (rx_dat_ev) err_d = 1'b1;
        if (tx_done_ev) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign regs = regs_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_basic_uart_cmd_responder.sv
// Transaction-level bench: a byte-array register model predicts replies, error pulses and the register vector.
module tb_basic_uart_cmd_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   rx_dat = 8'h00;
  logic         rx_dat_ev = 1'b0;
  logic         tx_ready = 1'b1;
  logic         tx_done_ev = 1'b0;
  logic [7:0]   tx_dat;
  logic         tx_wr_ev;
  logic [127:0] regs;
  logic         busy;
  logic         err_ev;

  int checks = 0;
  int errors = 0;
  logic [7:0] mregs [16];

  basic_uart_cmd_responder #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .rx_dat(rx_dat), .rx_dat_ev(rx_dat_ev),
    .tx_ready(tx_ready), .tx_done_ev(tx_done_ev), .tx_dat(tx_dat),
    .tx_wr_ev(tx_wr_ev), .regs(regs), .busy(busy), .err_ev(err_ev)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_vec();
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = mregs[k];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_err, input string tag);
    @(negedge clk);
    rx_dat    = b;
    rx_dat_ev = 1'b1;
    tick();
    rx_dat_ev = 1'b0;
    chk({tag, "_err"}, err_ev, exp_err);
  endtask

  task automatic wait_wr(input logic [7:0] exp, input string tag);
    logic got = 1'b0;
    for (int n = 0; n < 30 && !got; n++) begin
      tick();
      got = tx_wr_ev;
    end
    chk({tag, "_wr"}, got, 1'b1);
    chk({tag, "_dat"}, tx_dat, exp);
    tick();
    chk({tag, "_wr1cyc"}, tx_wr_ev, 1'b0);
  endtask

  task automatic finish_done(input logic [7:0] exp, input string tag);
    @(negedge clk);
    tx_done_ev = 1'b1;
    tick();
    tx_done_ev = 1'b0;
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_hold"}, tx_dat, exp);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input string tag);
    send_byte(8'h57, 1'b0, tag);
    send_byte({4'h0, a}, 1'b0, tag);
    send_byte(d, 1'b0, tag);
    mregs[a] = d;
    wait_wr(8'h06, tag);
    finish_done(8'h06, tag);
    chk({tag, "_regs"}, regs, model_vec());
  endtask

  task automatic do_read(input logic [3:0] a, input string tag);
    logic [7:0] e;
    e = mregs[a];
    send_byte(8'h52, 1'b0, tag);
    send_byte({4'h0, a}, 1'b0, tag);
    wait_wr(e, tag);
    finish_done(e, tag);
  endtask

  initial begin
    logic [7:0] b;
    int first;
    logic saw_wr;
    int pulses;

    for (int k = 0; k < 16; k++) mregs[k] = 8'h00;
    repeat (3) tick();
    chk("rst_txdat", tx_dat, 8'h00);
    chk("rst_wr", tx_wr_ev, 1'b0);
    chk("rst_regs", regs, 128'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_ev, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    do_write(4'h3, 8'hA5, "wr3");
    chk("reg3_byte", regs[31:24], 8'hA5);
    do_read(4'h3, "rd3");

    send_byte(8'h41, 1'b1, "badcmd");
    wait_wr(8'h15, "badcmd");
    finish_done(8'h15, "badcmd");

    send_byte(8'h52, 1'b0, "rdbad");
    send_byte(8'h10, 1'b1, "rdbad_a");
    wait_wr(8'h15, "rdbad");
    finish_done(8'h15, "rdbad");

    send_byte(8'h57, 1'b0, "wrbad");
    send_byte(8'h1F, 1'b1, "wrbad_a");
    wait_wr(8'h15, "wrbad");
    send_byte(8'h00, 1'b1, "wrbad_drop");
    finish_done(8'h15, "wrbad");
    chk("wrbad_regs", regs, model_vec());

    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 3))
        0: do_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), "rnd_wr");
        1: do_read(4'($urandom_range(0, 15)), "rnd_rd");
        2: begin
          do b = 8'($urandom_range(0, 255)); while (b == 8'h57 || b == 8'h52);
          send_byte(b, 1'b1, "rnd_cmd");
          wait_wr(8'h15, "rnd_cmd");
          finish_done(8'h15, "rnd_cmd");
        end
        default: begin
          send_byte(($urandom_range(0, 1) != 0) ? 8'h57 : 8'h52, 1'b0, "rnd_addr");
          send_byte(8'($urandom_range(16, 255)), 1'b1, "rnd_addr_a");
          wait_wr(8'h15, "rnd_addr");
          finish_done(8'h15, "rnd_addr");
          chk("rnd_addr_regs", regs, model_vec());
        end
      endcase
    end

    // Silence after a command byte: error pulse lands 100 edges after the byte edge.
    send_byte(8'h57, 1'b0, "to");
    first = 0;
    saw_wr = 1'b0;
    for (int n = 1; n <= 120 && first == 0; n++) begin
      tick();
      if (tx_wr_ev) saw_wr = 1'b1;
      if (err_ev) first = n;
    end
    chk("to_cycle", first, 100);
    chk("to_idle", busy, 1'b0);
    chk("to_nowr", saw_wr, 1'b0);
    chk("to_regs", regs, model_vec());

    // A byte landing exactly in the timeout cycle is accepted.
    send_byte(8'h57, 1'b0, "to2");
    repeat (99) tick();
    send_byte(8'h02, 1'b0, "to2_a");
    chk("to2_busy", busy, 1'b1);
    send_byte(8'h3C, 1'b0, "to2_d");
    mregs[2] = 8'h3C;
    wait_wr(8'h06, "to2");
    finish_done(8'h06, "to2");
    chk("to2_regs", regs, model_vec());

    // Transmitter held busy: no reply until tx_ready rises, then exactly one pulse.
    @(negedge clk);
    tx_ready = 1'b0;
    send_byte(8'h52, 1'b0, "rdy");
    send_byte(8'h02, 1'b0, "rdy_a");
    pulses = 0;
    repeat (50) begin
      tick();
      if (tx_wr_ev) pulses++;
    end
    chk("rdy_hold", pulses, 0);
    chk("rdy_busy", busy, 1'b1);
    @(negedge clk);
    tx_ready = 1'b1;
    wait_wr(8'h3C, "rdy");
    pulses = 0;
    repeat (5) begin
      tick();
      if (tx_wr_ev) pulses++;
    end
    chk("rdy_single", pulses, 0);
    finish_done(8'h3C, "rdy");

    // Reset in GET_DATA aborts the write and clears everything.
    do_write(4'h5, 8'h77, "pre");
    send_byte(8'h57, 1'b0, "rstmid");
    send_byte(8'h05, 1'b0, "rstmid_a");
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) mregs[k] = 8'h00;
    chk("rstmid_txdat", tx_dat, 8'h00);
    chk("rstmid_wr", tx_wr_ev, 1'b0);
    chk("rstmid_regs", regs, model_vec());
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_err", err_ev, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    do_read(4'h5, "rstmid_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
